// File: rtl/vlc_bit_packer_pkg.sv
// Shared definitions for the variable-length code packer: default widths and
// the flush state machine encoding.
package vlc_bit_packer_pkg;

  localparam int CODE_W_DEF = 32;
  localparam int LEN_W_DEF  = 6;
  localparam int OUT_W_DEF  = 8;
  localparam int ACC_W_DEF  = 64;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } pk_state_e;

endpackage

// File: rtl/vlc_out_reg.sv
// Single-entry valid/ready output register that also counts loaded words.
module vlc_out_reg
  import vlc_bit_packer_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  output logic             free_o,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output logic [31:0]      cnt_o
);

  logic             valid_q;
  logic [OUT_W-1:0] data_q;
  logic [31:0]      cnt_q;

  // The slot may be refilled in the same cycle the consumer takes it.
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      cnt_q   <= cnt_q + 32'd1;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vlc_bit_packer.sv
// Packs variable-length codewords into fixed OUT_W-bit words with backpressure,
// selectable bit order and a flush that pads the final partial word.
module vlc_bit_packer
  import vlc_bit_packer_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PAD_BIT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              flush_done,
  output logic [31:0]       word_cnt,
  output logic              busy
);

  if (LEN_W < $clog2(CODE_W + 1)) begin : g_bad_len_w
    $error("vlc_bit_packer: LEN_W too small to hold CODE_W");
  end
  if (OUT_W < 8 || OUT_W > CODE_W) begin : g_bad_out_w
    $error("vlc_bit_packer: OUT_W must satisfy 8 <= OUT_W <= CODE_W");
  end
  if (ACC_W < CODE_W + OUT_W) begin : g_bad_acc_w
    $error("vlc_bit_packer: ACC_W must be >= CODE_W + OUT_W");
  end

  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ACC_W_F  = FILL_W'(ACC_W);
  localparam logic [FILL_W-1:0] ROOM_F   = FILL_W'(ACC_W - CODE_W);
  localparam logic [LEN_W-1:0]  CODE_W_L = LEN_W'(CODE_W);

  function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

  pk_state_e         state_q;
  logic              flush_done_q;
  logic [ACC_W-1:0]  acc_q, acc_d, acc_ins, code_ext;
  logic [FILL_W-1:0] fill_q, fill_d, fill_ins, len_f, shamt;
  logic [LEN_W-1:0]  len_eff;
  logic [CODE_W-1:0] code_m;
  logic [OUT_W-1:0]  word_full, pad_mask, load_data;
  logic              accept, out_free, emit_full, emit_pad, load;

  assign in_ready   = (state_q == ST_RUN) && (fill_q <= ROOM_F);
  assign accept     = in_valid && in_ready;
  assign flush_done = flush_done_q;
  assign busy       = (fill_q != '0) || out_valid || (state_q != ST_RUN);
  assign emit_full  = out_free && (fill_q >= OUT_W_F);
  assign emit_pad   = out_free && (state_q == ST_FLUSH) && (fill_q != '0) && (fill_q < OUT_W_F);
  assign load       = emit_full || emit_pad;

  always_comb begin
    len_eff  = (in_len > CODE_W_L) ? CODE_W_L : in_len;
    len_f    = FILL_W'(len_eff);
    code_m   = in_code & len_mask(len_eff);
    code_ext = ACC_W'(code_m);
    shamt    = ACC_W_F - fill_q - len_f;
    acc_ins  = acc_q;
    fill_ins = fill_q;
    if (accept) begin
      // MSB mode keeps the oldest bit at the accumulator top; LSB mode at bit 0.
      if (MSB_FIRST) acc_ins = acc_q | (code_ext << shamt);
      else           acc_ins = acc_q | (code_ext << fill_q);
      fill_ins = fill_q + len_f;
    end
    if (MSB_FIRST) begin
      word_full = acc_q[ACC_W-1 -: OUT_W];
      pad_mask  = {OUT_W{1'b1}} >> fill_q;
    end else begin
      word_full = acc_q[OUT_W-1:0];
      pad_mask  = {OUT_W{1'b1}} << fill_q;
    end
    load_data = word_full;
    acc_d     = acc_ins;
    fill_d    = fill_ins;
    if (emit_full) begin
      // Emitted bits come from the old contents, so inserting first is safe.
      acc_d  = MSB_FIRST ? (acc_ins << OUT_W) : (acc_ins >> OUT_W);
      fill_d = fill_ins - OUT_W_F;
    end else if (emit_pad) begin
      load_data = word_full | (PAD_BIT ? pad_mask : '0);
      acc_d     = '0;
      fill_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
      acc_q        <= '0;
      fill_q       <= '0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= 1'b0;
      case (state_q)
        ST_RUN:   if (flush) state_q <= ST_FLUSH;
        ST_FLUSH: if (fill_q == '0 && out_free) state_q <= ST_DONE;
        ST_DONE: begin
          flush_done_q <= 1'b1;
          state_q      <= ST_RUN;
        end
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  vlc_out_reg #(.OUT_W(OUT_W)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (load_data),
    .free_o  (out_free),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .cnt_o   (word_cnt)
  );

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Directed bench for vlc_bit_packer: one MSB-first instance and two LSB-first
// instances (pad 1 / pad 0) driven by the same stimulus.
module tb_vlc_bit_packer;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_code;
  logic [5:0]  in_len;

  logic        m_rdy, m_ov, m_fd, m_busy;
  logic [7:0]  m_od;
  logic [31:0] m_cnt;
  logic        a_rdy, a_ov, a_fd, a_busy;
  logic [7:0]  a_od;
  logic [31:0] a_cnt;
  logic        b_rdy, b_ov, b_fd, b_busy;
  logic [7:0]  b_od;
  logic [31:0] b_cnt;

  always #5 clk = ~clk;

  vlc_bit_packer #(.MSB_FIRST(1'b1), .PAD_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_rdy), .in_code(in_code),
    .in_len(in_len), .flush(flush), .out_valid(m_ov), .out_ready(out_ready),
    .out_data(m_od), .flush_done(m_fd), .word_cnt(m_cnt), .busy(m_busy));

  vlc_bit_packer #(.MSB_FIRST(1'b0), .PAD_BIT(1'b1)) u_lsb_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy), .in_code(in_code),
    .in_len(in_len), .flush(flush), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .flush_done(a_fd), .word_cnt(a_cnt), .busy(a_busy));

  vlc_bit_packer #(.MSB_FIRST(1'b0), .PAD_BIT(1'b0)) u_lsb_p0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy), .in_code(in_code),
    .in_len(in_len), .flush(flush), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .flush_done(b_fd), .word_cnt(b_cnt), .busy(b_busy));

  logic [7:0] q_m[$], q_a[$], q_b[$];
  int         qc_m[$];
  int         fd_cnt = 0;
  int         cyc_now = 0;

  // Transfers are captured on the falling edge, when inputs and outputs are stable.
  always @(negedge clk) begin
    cyc_now <= cyc_now + 1;
    if (!rst) begin
      if (m_ov && out_ready) begin q_m.push_back(m_od); qc_m.push_back(cyc_now); end
      if (a_ov && out_ready) q_a.push_back(a_od);
      if (b_ov && out_ready) q_b.push_back(b_od);
      if (m_fd) fd_cnt <= fd_cnt + 1;
    end
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] code, input logic [5:0] len);
    bit r;
    int n;
    in_code  = code;
    in_len   = len;
    in_valid = 1'b1;
    n = 0;
    do begin
      r = m_rdy;
      @(posedge clk); #1;
      n++;
    end while (!r && n < 100);
    in_valid = 1'b0;
    if (!r) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_words(input int base, input int n, input string tag);
    int k;
    k = 0;
    while (q_m.size() < base + n && k < 400) begin @(posedge clk); #1; k++; end
    chk(tag, 64'(q_m.size() - base), 64'(n));
  endtask

  logic [7:0] pat_m [4];
  logic [7:0] pat_l [4];

  initial begin
    int base, fd0, sent, cyc, bad, bad_l;
    bit r, rdy29;
    pat_m = '{8'hAB, 8'hCD, 8'hEF, 8'h01};
    pat_l = '{8'h01, 8'hEF, 8'hCD, 8'hAB};
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_code = '0; in_len = '0;

    // 1: reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(m_ov), 64'd0);
    chk("rst_out_data", 64'(m_od), 64'd0);
    chk("rst_flush_done", 64'(m_fd), 64'd0);
    chk("rst_word_cnt", 64'(m_cnt), 64'd0);
    chk("rst_in_ready", 64'(m_rdy), 64'd1);
    chk("rst_busy", 64'(m_busy), 64'd0);

    // 2: (0x5,3),(0x1F,5) then flush
    base = q_m.size(); fd0 = fd_cnt;
    send(32'h5, 6'd3);
    send(32'h1F, 6'd5);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(8);
    chk("t2_words", 64'(q_m.size() - base), 64'd1);
    chk("t2_msb_word", 64'(q_m[base]), 64'hBF);
    chk("t2_lsb_word", 64'(q_b[base]), 64'hFD);
    chk("t2_word_cnt", 64'(m_cnt), 64'd1);
    chk("t2_flush_done", 64'(fd_cnt - fd0), 64'd1);

    // 3: (0x3,2) offered together with flush, padded
    base = q_m.size(); fd0 = fd_cnt;
    in_code = 32'h3; in_len = 6'd2; in_valid = 1'b1; flush = 1'b1;
    tick(1);
    in_valid = 1'b0; flush = 1'b0;
    tick(8);
    chk("t3_words", 64'(q_m.size() - base), 64'd1);
    chk("t3_lsb_pad1", 64'(q_a[base]), 64'hFF);
    chk("t3_lsb_pad0", 64'(q_b[base]), 64'h03);
    chk("t3_msb_pad0", 64'(q_m[base]), 64'hC0);
    chk("t3_flush_done", 64'(fd_cnt - fd0), 64'd1);
    chk("t3_word_cnt", 64'(m_cnt), 64'd2);

    // 4: 32 full-width codes, no stall
    base = q_m.size();
    for (int i = 0; i < 32; i++) send(32'hABCDEF01, 6'd32);
    wait_words(base, 128, "t4_words");
    bad = 0; bad_l = 0;
    for (int i = 0; i < 128; i++) begin
      if (q_m[base + i] !== pat_m[i % 4]) bad++;
      if (q_b[base + i] !== pat_l[i % 4]) bad_l++;
    end
    chk("t4_msb_bytes_bad", 64'(bad), 64'd0);
    chk("t4_lsb_bytes_bad", 64'(bad_l), 64'd0);
    chk("t4_no_gaps", 64'(qc_m[base + 127] - qc_m[base]), 64'd127);
    chk("t4_word_cnt", 64'(m_cnt), 64'd130);

    // 5: same stream with a 20-cycle output stall
    base = q_m.size(); sent = 0; cyc = 0; bad = 0; rdy29 = 1'b1;
    while (sent < 32 && cyc < 600) begin
      out_ready = !(cyc >= 10 && cyc < 30);
      if (cyc >= 11 && cyc < 30) begin
        if (!(m_ov === 1'b1 && m_od === pat_m[(q_m.size() - base) % 4])) bad++;
      end
      if (cyc == 29) rdy29 = m_rdy;
      in_code = 32'hABCDEF01; in_len = 6'd32; in_valid = 1'b1;
      r = m_rdy;
      tick(1);
      if (r) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t5_sent", 64'(sent), 64'd32);
    chk("t5_held_bad", 64'(bad), 64'd0);
    chk("t5_in_ready_stalled", 64'(rdy29), 64'd0);
    wait_words(base, 128, "t5_words");
    bad = 0;
    for (int i = 0; i < 128; i++) if (q_m[base + i] !== pat_m[i % 4]) bad++;
    chk("t5_bytes_bad", 64'(bad), 64'd0);
    chk("t5_word_cnt", 64'(m_cnt), 64'd258);

    // 6: clamped and zero lengths, empty flush, then reset mid-flush
    base = q_m.size();
    send(32'h12345678, 6'd40);
    send(32'hFFFFFFFF, 6'd0);
    send(32'h0000009A, 6'd8);
    wait_words(base, 5, "t6_words");
    tick(4);
    chk("t6_m0", 64'(q_m[base]), 64'h12);
    chk("t6_m3", 64'(q_m[base + 3]), 64'h78);
    chk("t6_m4", 64'(q_m[base + 4]), 64'h9A);
    chk("t6_l0", 64'(q_b[base]), 64'h78);
    chk("t6_l4", 64'(q_b[base + 4]), 64'h9A);
    chk("t6_idle_busy", 64'(m_busy), 64'd0);
    fd0 = fd_cnt;
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(1);
    chk("t6_fd_early", 64'(m_fd), 64'd0);
    tick(1);
    chk("t6_fd_pulse", 64'(m_fd), 64'd1);
    tick(5);
    chk("t6_no_extra_word", 64'(q_m.size() - base), 64'd5);
    chk("t6_fd_count", 64'(fd_cnt - fd0), 64'd1);
    chk("t6_word_cnt", 64'(m_cnt), 64'd263);

    out_ready = 1'b0;
    send(32'h0000FFFF, 6'd16);
    flush = 1'b1; tick(1); flush = 1'b0;
    tick(2);
    chk("t6_busy_in_flush", 64'(m_busy), 64'd1);
    fd0 = fd_cnt;
    rst = 1'b1; tick(1); rst = 1'b0;
    out_ready = 1'b1;
    chk("t6_rst_busy", 64'(m_busy), 64'd0);
    chk("t6_rst_out_valid", 64'(m_ov), 64'd0);
    chk("t6_rst_word_cnt", 64'(m_cnt), 64'd0);
    chk("t6_rst_in_ready", 64'(m_rdy), 64'd1);
    tick(6);
    chk("t6_rst_no_fd", 64'(fd_cnt - fd0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
